// File: rtl/draw_rect_scaled_if.sv
// VGA pipeline bundle: pixel counters, syncs, blanking and colour, passed
// between draw stages. The producer drives the "out" view, the consumer reads "in".
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_rect_scaled.sv
// Sprite overlay stage: draws a scaled bitmap from a synchronous pixel ROM at a
// position/enable latched once per frame, with optional colour-key transparency.
module draw_rect_scaled #(
  parameter int          RECT_WIDTH        = 48,
  parameter int          RECT_HEIGHT       = 64,
  parameter int          SCALE_LOG2        = 0,
  parameter int          ADDR_WIDTH        = 12,
  parameter int          TRANSPARENT_EN    = 0,
  parameter logic [11:0] TRANSPARENT_COLOR = 12'hF0F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [11:0]           x_pos,
  input  logic [11:0]           y_pos,
  input  logic [11:0]           rgb_pixel,
  output logic [ADDR_WIDTH-1:0] pixel_addr,
  vga_if.in                     in,
  vga_if.out                    out
);

  localparam logic [12:0] DW = 13'(RECT_WIDTH << SCALE_LOG2);
  localparam logic [12:0] DH = 13'(RECT_HEIGHT << SCALE_LOG2);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } timing_t;

  timing_t                 in_t;
  timing_t                 st1_q, st2_q, out_q, out_d;
  logic                    inside1_q, inside2_q, inside_d;
  logic [11:0]             xs_q, xs_d, ys_q, ys_d;
  logic                    en_q, en_d;
  logic [ADDR_WIDTH-1:0]   pixel_addr_q, pixel_addr_d;
  logic                    vblnk_rise;
  logic [12:0]             hc13, vc13, xs13, ys13, lx, ly, col, row;
  logic                    key_hit;

  always_comb begin
    in_t = '{hcount: in.hcount, vcount: in.vcount, hsync: in.hsync, vsync: in.vsync,
             hblnk: in.hblnk, vblnk: in.vblnk, rgb: in.rgb};
  end

  // st1_q.vblnk is in.vblnk delayed one clock, so it doubles as the edge detector.
  assign vblnk_rise = in.vblnk && !st1_q.vblnk;

  always_comb begin
    xs_d = vblnk_rise ? x_pos  : xs_q;
    ys_d = vblnk_rise ? y_pos  : ys_q;
    en_d = vblnk_rise ? enable : en_q;
  end

  // Bounds at 13 bits so the right/bottom edge cannot wrap past screen zero.
  always_comb begin
    hc13     = {2'b00, in.hcount};
    vc13     = {2'b00, in.vcount};
    xs13     = {1'b0, xs_q};
    ys13     = {1'b0, ys_q};
    inside_d = (hc13 >= xs13) && (hc13 < xs13 + DW) &&
               (vc13 >= ys13) && (vc13 < ys13 + DH);
    lx       = hc13 - xs13;
    ly       = vc13 - ys13;
    col      = lx >> SCALE_LOG2;
    row      = ly >> SCALE_LOG2;
    pixel_addr_d = inside_d ? ADDR_WIDTH'(32'(row) * RECT_WIDTH + 32'(col)) : '0;
  end

  // NOTE: every signal assigned in an always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    key_hit = (TRANSPARENT_EN != 0) && (rgb_pixel == TRANSPARENT_COLOR);
    out_d   = st2_q;
    if (st2_q.hblnk || st2_q.vblnk) begin
      out_d.rgb = 12'h000;
    end else if (inside2_q && en_q && !key_hit) begin
      out_d.rgb = rgb_pixel;
    end else begin
      out_d.rgb = st2_q.rgb;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; the async reset clears the whole pipeline at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q         <= '0;
      ys_q         <= '0;
      en_q         <= 1'b0;
      st1_q        <= '0;
      st2_q        <= '0;
      out_q        <= '0;
      inside1_q    <= 1'b0;
      inside2_q    <= 1'b0;
      pixel_addr_q <= '0;
    end else begin
      xs_q         <= xs_d;
      ys_q         <= ys_d;
      en_q         <= en_d;
      st1_q        <= in_t;
      st2_q        <= st1_q;
      out_q        <= out_d;
      inside1_q    <= inside_d;
      inside2_q    <= inside1_q;
      pixel_addr_q <= pixel_addr_d;
    end
  end

  assign pixel_addr = pixel_addr_q;

  always_comb begin
    out.hcount = out_q.hcount;
    out.vcount = out_q.vcount;
    out.hsync  = out_q.hsync;
    out.vsync  = out_q.vsync;
    out.hblnk  = out_q.hblnk;
    out.vblnk  = out_q.vblnk;
    out.rgb    = out_q.rgb;
  end

endmodule
